serial_adder_scheduler: RTL

Time-shares a single 4-bit ripple-carry adder slice between two requesters to perform WIDTH-bit add/subtract operations nibble-serially, LSB first. Sits between the ALU operand front-end and the shared adder datapath. Arbitration is round-robin, with valid/ready handshakes on both request ports and on the response port.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/nibble_adder_4b.sv | 22 ++
 rtl/serial_adder_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract scheduler.
// The datapath is built around a fixed 4-bit adder slice.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    // Operand width must split evenly into whole slices.
    function automatic bit width_ok(input int width);
        return (width >= NIBBLE) && ((width % NIBBLE) == 0);
    endfunction

endpackage

// File: rtl/nibble_adder_4b.sv
// Purely combinational 4-bit ripple-carry adder slice.
// This is the only arithmetic in the scheduler.
module nibble_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    always_comb begin
        logic c;
        c     = c_in;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/serial_adder_scheduler.sv
// Round-robin scheduler sharing one 4-bit adder slice between two requesters,
// computing WIDTH-bit add/subtract nibble-serially, LSB first.
module serial_adder_scheduler
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    localparam int NIB = WIDTH / NIBBLE;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder_scheduler: WIDTH must be a positive multiple of 4");
    end

    state_t state_reg, state_next;

    logic                         ptr_reg;
    logic                         grant;
    logic                         grant_valid;
    logic                         accept;
    logic [NIB-1:0][NIBBLE-1:0]   a_reg;
    logic [NIB-1:0][NIBBLE-1:0]   b_reg;
    logic [NIB-1:0][NIBBLE-1:0]   sum_reg;
    logic                         carry_reg;
    logic                         id_reg;
    logic                         cout_reg;
    logic                         ovf_reg;
    logic                         valid_reg;
    logic [CW-1:0]                cnt_reg;

    logic [WIDTH-1:0]             sel_a;
    logic [WIDTH-1:0]             sel_b;
    logic                         sel_sub;
    logic [NIBBLE-1:0]            slice_sum;
    logic                         slice_cout;

    // Pointer owner wins when valid; otherwise the other requester may go.
    always_comb begin
        grant       = ptr_reg;
        grant_valid = 1'b0;
        if (ptr_reg ? req1_valid : req0_valid) begin
            grant       = ptr_reg;
            grant_valid = 1'b1;
        end else if (ptr_reg ? req0_valid : req1_valid) begin
            grant       = ~ptr_reg;
            grant_valid = 1'b1;
        end
    end

    assign accept  = (state_reg == IDLE) && grant_valid;
    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_sub = grant ? req1_sub : req0_sub;

    nibble_adder_4b u_slice (
        .a     (a_reg[cnt_reg]),
        .b     (b_reg[cnt_reg]),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt_reg == LAST) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            id_reg    <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Subtract is A + ~B + 1: invert B, seed the carry.
                        a_reg     <= sel_a;
                        b_reg     <= sel_sub ? ~sel_b : sel_b;
                        carry_reg <= sel_sub;
                        id_reg    <= grant;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[cnt_reg] <= slice_sum;
                    carry_reg        <= slice_cout;
                    cnt_reg          <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        cout_reg  <= slice_cout;
                        ovf_reg   <= (a_reg[NIB-1][NIBBLE-1] == b_reg[NIB-1][NIBBLE-1]) &&
                                     (slice_sum[NIBBLE-1] != a_reg[NIB-1][NIBBLE-1]);
                        valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_reg <= 1'b0;
                        ptr_reg   <= ~id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = valid_reg;
    assign rsp_id    = id_reg;
    assign rsp_sum   = sum_reg;
    assign rsp_cout  = cout_reg;
    assign rsp_ovf   = ovf_reg;

endmodule
